// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader, imem and control unit.
// State encoding, NOP word and instruction field positions.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        FILL = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [7:0] NOP_WORD = 8'h00;

    localparam int OPC_MSB  = 7;
    localparam int OPC_LSB  = 5;
    localparam int RS_BIT   = 4;
    localparam int RTRD_BIT = 3;
    localparam int IMM_MSB  = 2;
    localparam int IMM_LSB  = 0;

endpackage

// File: rtl/imem_loader_if.sv
// Instruction-word stream into the loader.
// Valid/ready handshake with an end-of-image marker.
interface imem_loader_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/imem_write_port_reg.sv
// Registered imem write port: strobe, address and data.
// Cleared synchronously on reset so no write escapes a reset edge.
module imem_write_port_reg #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o
);
    logic              en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            en_q   <= wr_en_i;
            addr_q <= wr_addr_i;
            data_q <= wr_data_i;
        end
    end

    assign wr_en_o   = en_q;
    assign wr_addr_o = addr_q;
    assign wr_data_o = data_q;
endmodule

// File: rtl/imem_loader.sv
// Streams an instruction image into imem from address 0, optionally NOP-padding,
// and holds the core off until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 256,
    parameter int FILL_NOP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.slave      in_if,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;
    logic              we_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              accept;

    assign in_if.in_ready = (state_q == LOAD);
    assign accept         = in_if.in_valid && in_if.in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    // done/err/hold follow the state one cycle late so they land after the last write
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        hold_d  = 1'b1;
        we_d    = 1'b0;
        waddr_d = addr_q;
        wdata_d = DATA_W'(NOP_WORD);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    wdata_d = in_if.in_data;
                    count_d = count_q + 1'b1;
                    if (addr_q == LAST) begin
                        state_d = in_if.in_last ? DONE : ERR;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        if (in_if.in_last)
                            state_d = (FILL_NOP != 0) ? FILL : DONE;
                    end
                end
            end
            FILL: begin
                we_d = 1'b1;
                if (addr_q == LAST) state_d = DONE;
                else                addr_d  = addr_q + 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
                hold_d = 1'b0;
                if (start) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    count_d = '0;
                    done_d  = 1'b0;
                    hold_d  = 1'b1;
                end
            end
            ERR: begin
                err_d = 1'b1;
                if (start) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    imem_write_port_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wport (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (we_d),
        .wr_addr_i (waddr_d),
        .wr_data_i (wdata_d),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data)
    );

    assign core_hold = hold_q;
    assign done      = done_q;
    assign err       = err_q;
    assign count     = count_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (NOP fill on/off), DEPTH=8.
// Expected writes are queued when beats are driven and popped as wr_en appears.
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    always #5 clk = ~clk;

    imem_loader_if #(.DATA_W(8)) if0 ();
    imem_loader_if #(.DATA_W(8)) if1 ();

    logic       wr_en0, wr_en1;
    logic [7:0] wr_addr0, wr_addr1;
    logic [7:0] wr_data0, wr_data1;
    logic       core_hold0, core_hold1;
    logic       done0, done1;
    logic       err0, err1;
    logic [8:0] count0, count1;

    imem_loader #(.ADDR_W(8), .DATA_W(8), .DEPTH(8), .FILL_NOP(1)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .start     (start0),
        .in_if     (if0.slave),
        .wr_en     (wr_en0),
        .wr_addr   (wr_addr0),
        .wr_data   (wr_data0),
        .core_hold (core_hold0),
        .done      (done0),
        .err       (err0),
        .count     (count0)
    );

    imem_loader #(.ADDR_W(8), .DATA_W(8), .DEPTH(8), .FILL_NOP(0)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .in_if     (if1.slave),
        .wr_en     (wr_en1),
        .wr_addr   (wr_addr1),
        .wr_data   (wr_data1),
        .core_hold (core_hold1),
        .done      (done1),
        .err       (err1),
        .count     (count1)
    );

    int checks = 0;
    int failures = 0;
    int m0 = 0;
    int m1 = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [15:0] e;
        @(posedge clk);
        #1;
        if (wr_en0 === 1'b1) begin
            checks++;
            assert (q0.size() != 0) else begin
                failures++;
                $error("FAIL wr0_unexpected observed=%0h_%0h expected=none", wr_addr0, wr_data0);
            end
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("wr0_addr_data", 32'({wr_addr0, wr_data0}), 32'(e));
            end
        end
        if (wr_en1 === 1'b1) begin
            checks++;
            assert (q1.size() != 0) else begin
                failures++;
                $error("FAIL wr1_unexpected observed=%0h_%0h expected=none", wr_addr1, wr_data1);
            end
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("wr1_addr_data", 32'({wr_addr1, wr_data1}), 32'(e));
            end
        end
    endtask

    task automatic send(input int u, input logic [7:0] d, input logic last);
        if (u == 0) begin
            if0.in_valid = 1'b1; if0.in_data = d; if0.in_last = last;
            chk("in_ready0", 32'(if0.in_ready), 32'd1);
            q0.push_back({m0[7:0], d});
            m0++;
        end else begin
            if1.in_valid = 1'b1; if1.in_data = d; if1.in_last = last;
            chk("in_ready1", 32'(if1.in_ready), 32'd1);
            q1.push_back({m1[7:0], d});
            m1++;
        end
        tick();
        if (u == 0) begin
            chk("wr_lat0", 32'(wr_en0), 32'd1);
            if0.in_valid = 1'b0; if0.in_last = 1'b0;
        end else begin
            chk("wr_lat1", 32'(wr_en1), 32'd1);
            if1.in_valid = 1'b0; if1.in_last = 1'b0;
        end
    endtask

    task automatic start_load(input int u);
        if (u == 0) begin start0 = 1'b1; m0 = 0; end
        else        begin start1 = 1'b1; m1 = 0; end
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Expect NOP writes for every address from the model pointer to DEPTH-1
    task automatic fill_and_finish(input int cnt);
        int n;
        n = 8 - m0;
        for (int a = m0; a < 8; a++) q0.push_back({a[7:0], 8'h00});
        for (int i = 0; i < n; i++) begin
            tick();
            chk("fill_b2b", 32'(wr_en0), 32'd1);
            chk("fill_done_low", 32'(done0), 32'd0);
            chk("fill_hold_high", 32'(core_hold0), 32'd1);
        end
        m0 = 8;
        tick();
        chk("done_rise", 32'(done0), 32'd1);
        chk("hold_fall", 32'(core_hold0), 32'd0);
        chk("done_wr_idle", 32'(wr_en0), 32'd0);
        chk("done_count", 32'(count0), 32'(cnt));
        chk("done_err", 32'(err0), 32'd0);
        chk("done_ready", 32'(if0.in_ready), 32'd0);
        chk("q0_drained", 32'(q0.size()), 32'd0);
    endtask

    initial begin
        if0.in_valid = 1'b0; if0.in_data = 8'h00; if0.in_last = 1'b0;
        if1.in_valid = 1'b0; if1.in_data = 8'h00; if1.in_last = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_ready", 32'(if0.in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en0), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr0), 32'd0);
        chk("rst_wr_data", 32'(wr_data0), 32'd0);
        chk("rst_hold", 32'(core_hold0), 32'd1);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_count", 32'(count0), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_ready", 32'(if0.in_ready), 32'd0);

        // Normal load with NOP fill
        start_load(0);
        send(0, 8'h25, 1'b0);
        send(0, 8'h4A, 1'b0);
        send(0, 8'h93, 1'b1);
        fill_and_finish(3);

        // Restart from DONE with valid gaps 1,0,0,1,1
        start_load(0);
        chk("restart_done_clr", 32'(done0), 32'd0);
        chk("restart_hold", 32'(core_hold0), 32'd1);
        chk("restart_count", 32'(count0), 32'd0);
        send(0, 8'h11, 1'b0);
        tick();
        chk("gap1_wr", 32'(wr_en0), 32'd0);
        tick();
        chk("gap2_wr", 32'(wr_en0), 32'd0);
        send(0, 8'h22, 1'b0);
        send(0, 8'h33, 1'b1);
        fill_and_finish(3);

        // Overflow: eight beats without in_last
        start_load(0);
        for (int i = 0; i < 8; i++) send(0, 8'h10 + 8'(i), 1'b0);
        if0.in_valid = 1'b1; if0.in_data = 8'hFF;
        chk("ovf_ready", 32'(if0.in_ready), 32'd0);
        tick();
        chk("ovf_err", 32'(err0), 32'd1);
        chk("ovf_hold", 32'(core_hold0), 32'd1);
        chk("ovf_ready2", 32'(if0.in_ready), 32'd0);
        chk("ovf_wr", 32'(wr_en0), 32'd0);
        chk("ovf_count", 32'(count0), 32'd8);
        tick();
        chk("ovf_9th_wr", 32'(wr_en0), 32'd0);
        chk("ovf_done", 32'(done0), 32'd0);
        if0.in_valid = 1'b0;
        chk("ovf_q0", 32'(q0.size()), 32'd0);

        // Exact fit: in_last on the eighth beat, restarting from ERR
        start_load(0);
        chk("fit_err_clr", 32'(err0), 32'd0);
        for (int i = 0; i < 8; i++) send(0, 8'hA0 + 8'(i), (i == 7));
        tick();
        chk("fit_done", 32'(done0), 32'd1);
        chk("fit_err", 32'(err0), 32'd0);
        chk("fit_count", 32'(count0), 32'd8);
        chk("fit_wr", 32'(wr_en0), 32'd0);
        chk("fit_hold", 32'(core_hold0), 32'd0);
        chk("fit_q0", 32'(q0.size()), 32'd0);

        // Reset after two accepted beats
        start_load(0);
        send(0, 8'h5A, 1'b0);
        send(0, 8'h6B, 1'b0);
        reset = 1'b1;
        tick();
        chk("mid_rst_ready", 32'(if0.in_ready), 32'd0);
        chk("mid_rst_wr", 32'(wr_en0), 32'd0);
        chk("mid_rst_count", 32'(count0), 32'd0);
        chk("mid_rst_hold", 32'(core_hold0), 32'd1);
        chk("mid_rst_done", 32'(done0), 32'd0);
        reset = 1'b0;
        if0.in_valid = 1'b1; if0.in_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_wr", 32'(wr_en0), 32'd0);
            chk("post_rst_ready", 32'(if0.in_ready), 32'd0);
        end
        if0.in_valid = 1'b0;

        // FILL_NOP=0 instance: load, then restart from DONE
        start_load(1);
        send(1, 8'h3C, 1'b0);
        send(1, 8'h7F, 1'b1);
        tick();
        chk("nf_done", 32'(done1), 32'd1);
        chk("nf_count", 32'(count1), 32'd2);
        chk("nf_no_fill", 32'(wr_en1), 32'd0);
        start_load(1);
        chk("nf_done_clr", 32'(done1), 32'd0);
        chk("nf_hold_set", 32'(core_hold1), 32'd1);
        send(1, 8'hE1, 1'b1);
        tick();
        chk("nf_redone", 32'(done1), 32'd1);
        chk("nf_recount", 32'(count1), 32'd1);
        chk("nf_rehold", 32'(core_hold1), 32'd0);
        chk("nf_err", 32'(err1), 32'd0);
        tick();
        chk("nf_idle_wr", 32'(wr_en1), 32'd0);
        chk("nf_q1", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
